// File: rtl/brg_rf_nr1w.sv
`default_nettype none
// ============================================================================
// Module   : brg_rf_nr1w
// Purpose  : Parametrised N-read / 1-write register file. Each read port owns
//            a private 1R1W bank copy and every write is broadcast to all
//            copies. Reads are synchronous and hold their value when idle.
//            After reset an init sequencer zeroes every entry (one entry per
//            clock) before ready_o rises. Entry 0 can be hardwired to zero.
// Ports    : clk_i      - clock, all state on rising edge
//            reset_i    - asynchronous active-low reset
//            ready_o    - 1 once the init pass is complete
//            w_v_i      - write enable
//            w_addr_i   - write address
//            w_data_i   - write data
//            r_v_i      - per-port read enable
//            r_addr_i   - packed read addresses, port k at [k*aw +: aw]
//            r_data_o   - packed read data, port k at [k*width_p +: width_p]
// Config   : BRG_RF_BYPASS_EN defined   -> same-cycle write/read collision
//                                          returns the new data (write-first)
//            BRG_RF_BYPASS_EN undefined -> collision returns the old data
//                                          (read-first)
// Revision : 1.0 - initial release
// ============================================================================
module brg_rf_nr1w #(
  parameter  int width_p       = 32,
  parameter  int els_p         = 32,
  parameter  int read_ports_p  = 2,
  parameter  int zero_reg_p    = 1,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  output logic                                   ready_o,
  input  logic                                   w_v_i,
  input  logic [addr_width_lp-1:0]               w_addr_i,
  input  logic [width_p-1:0]                     w_data_i,
  input  logic [read_ports_p-1:0]                r_v_i,
  input  logic [read_ports_p*addr_width_lp-1:0]  r_addr_i,
  output logic [read_ports_p*width_p-1:0]        r_data_o
);

  // State encoding
  localparam logic [0:0] c_st_init  = 1'b0;
  localparam logic [0:0] c_st_ready = 1'b1;

  // Last entry index and entry count sized for address comparisons. The
  // count carries one extra bit because els_p may equal 2**addr_width_lp.
  localparam logic [addr_width_lp-1:0] c_last_addr = addr_width_lp'(els_p - 1);
  localparam logic [addr_width_lp:0]   c_els       = (addr_width_lp + 1)'(els_p);

  logic [0:0]               r_state;
  logic [0:0]               w_state_nxt;
  logic [addr_width_lp-1:0] r_init_cnt;
  logic                     w_init_last;
  logic                     w_init_active;
  logic                     w_ready;

  logic                     w_wr_in_range;
  logic                     w_wr_is_zero;
  logic                     w_user_we;
  logic                     w_mem_we;
  logic [addr_width_lp-1:0] w_mem_addr;
  logic [width_p-1:0]       w_mem_data;

  assign w_init_last = (r_init_cnt == c_last_addr);

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= c_st_init;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_init:  if (w_init_last) w_state_nxt = c_st_ready;
      c_st_ready: w_state_nxt = c_st_ready;
      default:    w_state_nxt = c_st_init;
    endcase
  end

  always_comb begin
    w_init_active = 1'b0;
    w_ready       = 1'b0;
    case (r_state)
      c_st_init:  w_init_active = 1'b1;
      c_st_ready: w_ready       = 1'b1;
      default:    w_init_active = 1'b1;
    endcase
  end

  assign ready_o = w_ready;

  // Init counter walks entries 0..els_p-1; it parks on the last entry once
  // READY is reached and restarts only on the next reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_init_cnt <= '0;
    end else if (w_init_active && !w_init_last) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared write port: the init sequencer owns it during INIT, the user
  // afterwards. Out-of-range and zero-register writes never reach storage.
  // Held off while reset is low so that reset itself never alters memory.
  // ---------------------------------------------------------------------------
  assign w_wr_in_range = ({1'b0, w_addr_i} < c_els);
  assign w_wr_is_zero  = (zero_reg_p != 0) && (w_addr_i == '0);
  assign w_user_we     = w_ready && w_v_i && w_wr_in_range && !w_wr_is_zero;
  assign w_mem_we      = reset_i && (w_init_active || w_user_we);
  assign w_mem_addr    = w_init_active ? r_init_cnt : w_addr_i;
  assign w_mem_data    = w_init_active ? '0 : w_data_i;

  // ---------------------------------------------------------------------------
  // One bank copy plus one output register per read port
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < read_ports_p; k++) begin : g_port
    logic [width_p-1:0]       r_bank [els_p];
    logic [width_p-1:0]       r_rdata;
    logic [width_p-1:0]       w_rd_val;
    logic [addr_width_lp-1:0] w_raddr;
    logic                     w_rd_in_range;
    logic                     w_rd_is_zero;
    logic                     w_rd_hit;

    assign w_raddr       = r_addr_i[k*addr_width_lp +: addr_width_lp];
    assign w_rd_in_range = ({1'b0, w_raddr} < c_els);
    assign w_rd_is_zero  = (zero_reg_p != 0) && (w_raddr == '0);

    // w_user_we already excludes zero-reg and out-of-range targets, so a hit
    // can only occur on an address whose read is not forced to zero.
`ifdef BRG_RF_BYPASS_EN
    assign w_rd_hit = w_user_we && (w_addr_i == w_raddr);
`else
    assign w_rd_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
        r_bank[w_mem_addr] <= w_mem_data;
      end
    end

    always_comb begin
      w_rd_val = '0;
      if (!w_rd_in_range || w_rd_is_zero) begin
        w_rd_val = '0;
      end else if (w_rd_hit) begin
        w_rd_val = w_data_i;
      end else begin
        w_rd_val = r_bank[w_raddr];
      end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        r_rdata <= '0;
      end else if (w_ready && r_v_i[k]) begin
        r_rdata <= w_rd_val;
      end
    end

    assign r_data_o[k*width_p +: width_p] = r_rdata;
  end

endmodule
`default_nettype wire
